// File: rtl/axi_stream_pattern_src.sv
// Stream pattern source: emits runs of fixed-length packets with valid/ready handshaking.
// Define AXIS_SRC_LFSR_EN for a 16-bit LFSR payload; otherwise the payload is an incrementing counter.
module axi_stream_pattern_src #(
    parameter int DWIDTH     = 8,
    parameter int PKT_LEN    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic              aclk_i,
    input  logic              areset_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  pkt_num_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  pkt_cnt_o
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic FIRST_IS_LAST = (PKT_LEN == 1);

`ifdef AXIS_SRC_LFSR_EN
    localparam int PAY_W = 16;
    localparam logic [PAY_W-1:0] PAY_SEED = 16'hACE1;
`else
    localparam int PAY_W = DWIDTH;
    localparam logic [PAY_W-1:0] PAY_SEED = '0;
`endif

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [PAY_W-1:0]  pay_q, pay_d, pay_step;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;

    // Payload generator advances only on an accepted beat, so stalls never skip or repeat values.
`ifdef AXIS_SRC_LFSR_EN
    assign pay_step = {pay_q[0] ^ pay_q[2] ^ pay_q[3] ^ pay_q[5], pay_q[15:1]};
`else
    assign pay_step = pay_q + PAY_W'(1);
`endif

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            state_q   <= IDLE;
            num_q     <= '0;
            pkt_cnt_q <= '0;
            beat_q    <= '0;
            gap_q     <= '0;
            pay_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            pkt_cnt_q <= pkt_cnt_d;
            beat_q    <= beat_d;
            gap_q     <= gap_d;
            pay_q     <= pay_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        pkt_cnt_d = pkt_cnt_q;
        beat_d    = beat_q;
        gap_d     = gap_q;
        pay_d     = pay_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pkt_cnt_d = '0;
                    if (pkt_num_i != '0) begin
                        state_d = SEND;
                        num_d   = pkt_num_i;
                        beat_d  = '0;
                        pay_d   = PAY_SEED;
                        valid_d = 1'b1;
                        last_d  = FIRST_IS_LAST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (valid_q && ready_i) begin
                    pay_d = pay_step;
                    if (beat_q == LAST_BEAT) begin
                        beat_d    = '0;
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        if (pkt_cnt_q + CNT_W'(1) == num_q) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            last_d = FIRST_IS_LAST;
                        end else begin
                            state_d = GAP;
                            gap_d   = '0;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        last_d = ((beat_q + BEAT_W'(1)) == LAST_BEAT);
                    end
                end
            end
            GAP: begin
                if (gap_q == LAST_GAP) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    last_d  = FIRST_IS_LAST;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign valid_o   = valid_q;
    assign data_o    = pay_q[DWIDTH-1:0];
    assign last_o    = last_q;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_axi_stream_pattern_src.sv
// Bench for axi_stream_pattern_src: random ready/start noise checked against a beat-index model.
// Honours AXIS_SRC_LFSR_EN when computing expected payloads.
module tb_axi_stream_pattern_src;

    localparam int DW  = 8;
    localparam int PL  = 4;
    localparam int GP  = 2;
    localparam int CW  = 16;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] pkt_num = '0;
    logic          ready = 1'b0;
    logic          valid, last, busy, done;
    logic [DW-1:0] data;
    logic [CW-1:0] pkt_cnt;

    logic          start_b = 1'b0;
    logic [CW-1:0] pkt_num_b = '0;
    logic          valid_b, last_b, busy_b, done_b;
    logic [DW-1:0] data_b;
    logic [CW-1:0] pkt_cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    axi_stream_pattern_src #(.DWIDTH(DW), .PKT_LEN(PL), .GAP_CYCLES(GP), .CNT_W(CW)) u_dut (
        .aclk_i(aclk), .areset_i(areset), .start_i(start), .pkt_num_i(pkt_num),
        .ready_i(ready), .valid_o(valid), .data_o(data), .last_o(last),
        .busy_o(busy), .done_o(done), .pkt_cnt_o(pkt_cnt)
    );

    axi_stream_pattern_src #(.DWIDTH(DW), .PKT_LEN(PL), .GAP_CYCLES(0), .CNT_W(CW)) u_dut_b2b (
        .aclk_i(aclk), .areset_i(areset), .start_i(start_b), .pkt_num_i(pkt_num_b),
        .ready_i(1'b1), .valid_o(valid_b), .data_o(data_b), .last_o(last_b),
        .busy_o(busy_b), .done_o(done_b), .pkt_cnt_o(pkt_cnt_b)
    );

    // Payload of the k-th accepted beat of a run, straight from the generator rule.
    function automatic logic [DW-1:0] expPayload(input int k);
`ifdef AXIS_SRC_LFSR_EN
        logic [15:0] r;
        r = 16'hACE1;
        for (int i = 0; i < k; i++) r = {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
        return r[DW-1:0];
`else
        return DW'(k % (1 << DW));
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [CW-1:0] n, input logic r);
        start   = s;
        pkt_num = n;
        ready   = r;
    endtask

    // mode 0: ready always 1; mode 1: random ready plus start noise; mode 2: 3-cycle stall on beat 2.
    // abortAt >= 0 asserts reset while that beat is presented and returns immediately.
    task automatic runPackets(input int num, input int mode, input int abortAt);
        int  k = 0;
        int  idle = 0;
        int  cycles = 0;
        int  stall = 0;
        bit  gapPending = 1'b0;
        bit  r;
        bit  noiseStart;
        logic [CW-1:0] noiseNum;
        applyStimulus(1'b1, CW'(num), 1'($urandom_range(0, 1)));
        while (1) begin
            @(negedge aclk);
            cycles++;
            if (cycles > 1000) begin
                checkOutput("run_timeout", 32'(cycles), 32'(0));
                applyStimulus(1'b0, '0, 1'b0);
                return;
            end
            checkOutput("busy", 32'(busy), 32'(1));
            checkOutput("done_mid_run", 32'(done), 32'(0));
            checkOutput("pkt_cnt", 32'(pkt_cnt), 32'(k / PL));
            if (valid) begin
                if (gapPending) begin
                    checkOutput("gap_len", 32'(idle), 32'(GP));
                    gapPending = 1'b0;
                end
                checkOutput("data", 32'(data), 32'(expPayload(k)));
                checkOutput("last", 32'(last), 32'((k % PL) == PL - 1));
            end else begin
                checkOutput("valid_drop", 32'({gapPending, idle < GP}), 32'(2'b11));
                idle++;
            end
            if (abortAt >= 0 && valid && k == abortAt) begin
                areset = 1'b1;
                applyStimulus(1'b0, '0, 1'b0);
                return;
            end
            case (mode)
                1:       r = ($urandom_range(0, 99) < 60);
                2: begin
                    r = !(valid && k == 2 && stall < 3);
                    if (!r) stall++;
                end
                default: r = 1'b1;
            endcase
            noiseStart = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            noiseNum   = CW'($urandom_range(1, 9));
            applyStimulus(noiseStart, noiseNum, r);
            if (valid && r) begin
                k++;
                if (k % PL == 0) begin
                    if (k == num * PL) break;
                    gapPending = 1'b1;
                    idle = 0;
                end
            end
        end
        @(negedge aclk);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("end_valid", 32'(valid), 32'(0));
        checkOutput("end_last", 32'(last), 32'(0));
        checkOutput("end_done", 32'(done), 32'(1));
        checkOutput("end_busy", 32'(busy), 32'(0));
        checkOutput("end_pkt_cnt", 32'(pkt_cnt), 32'(num));
    endtask

    initial begin
        $display("[TB] starting");
        repeat (3) @(negedge aclk);
        checkOutput("rst_valid", 32'(valid), 32'(0));
        checkOutput("rst_data", 32'(data), 32'(0));
        checkOutput("rst_last", 32'(last), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_done", 32'(done), 32'(0));
        checkOutput("rst_pkt_cnt", 32'(pkt_cnt), 32'(0));
        checkOutput("rst_valid_b", 32'(valid_b), 32'(0));
        areset = 1'b0;
        @(negedge aclk);

        // two packets with ready held high, then a stalled run started on the done cycle
        runPackets(2, 0, -1);
        runPackets(3, 2, -1);

        // zero-length run: only a done pulse
        applyStimulus(1'b1, '0, 1'b1);
        @(negedge aclk);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("zero_done", 32'(done), 32'(1));
        checkOutput("zero_valid", 32'(valid), 32'(0));
        checkOutput("zero_busy", 32'(busy), 32'(0));
        @(negedge aclk);
        checkOutput("zero_done_drop", 32'(done), 32'(0));
        checkOutput("zero_busy2", 32'(busy), 32'(0));

        for (int i = 0; i < 6; i++) runPackets($urandom_range(1, 5), 1, -1);

        // reset while beat 2 is presented aborts the run silently
        runPackets(3, 0, 2);
        @(negedge aclk);
        checkOutput("abort_valid", 32'(valid), 32'(0));
        checkOutput("abort_data", 32'(data), 32'(0));
        checkOutput("abort_last", 32'(last), 32'(0));
        checkOutput("abort_busy", 32'(busy), 32'(0));
        checkOutput("abort_done", 32'(done), 32'(0));
        checkOutput("abort_pkt_cnt", 32'(pkt_cnt), 32'(0));
        areset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checkOutput("abort_no_done", 32'(done), 32'(0));
            checkOutput("abort_idle", 32'(valid), 32'(0));
        end
        runPackets(1, 0, -1);

        // back-to-back packets without an idle gap
        start_b   = 1'b1;
        pkt_num_b = CW'(2);
        for (int i = 0; i < 2 * PL; i++) begin
            @(negedge aclk);
            start_b = 1'b0;
            checkOutput("b2b_valid", 32'(valid_b), 32'(1));
            checkOutput("b2b_data", 32'(data_b), 32'(expPayload(i)));
            checkOutput("b2b_last", 32'(last_b), 32'((i % PL) == PL - 1));
        end
        @(negedge aclk);
        checkOutput("b2b_done", 32'(done_b), 32'(1));
        checkOutput("b2b_end_valid", 32'(valid_b), 32'(0));
        checkOutput("b2b_pkt_cnt", 32'(pkt_cnt_b), 32'(2));
        @(negedge aclk);
        checkOutput("b2b_done_drop", 32'(done_b), 32'(0));
        checkOutput("b2b_busy", 32'(busy_b), 32'(0));

        @(negedge aclk);
        checkOutput("final_done", 32'(done), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
